// File: rtl/l2_fill_sequencer.sv
// L2 miss-fill sequencer: queues fill/unlock commands, obtains a victim way from
// the LRU, writes back dirty victims, installs the new tag and optionally locks it.
module l2_fill_sequencer #(
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 4,
    parameter int TAG_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int SW = $clog2(NUM_SETS),
    localparam int WW = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_unlock,
    input  logic [SW-1:0]        req_set,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [WW-1:0]        req_way,
    input  logic                 req_lock,
    output logic                 lru_fill_en,
    output logic [SW-1:0]        lru_fill_set,
    input  logic [WW-1:0]        lru_fill_way,
    output logic                 lru_lock_en,
    output logic                 lru_lock_value,
    output logic [WW-1:0]        lru_lock_way,
    input  logic                 victim_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [SW-1:0]        wb_set,
    output logic [WW-1:0]        wb_way,
    output logic                 tag_we,
    output logic [SW-1:0]        tag_set,
    output logic [WW-1:0]        tag_way,
    output logic [TAG_WIDTH-1:0] tag_value,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                 unlock;
        logic [SW-1:0]        set;
        logic [TAG_WIDTH-1:0] tag;
        logic [WW-1:0]        way;
        logic                 lock;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, VREQ, VCAP, WB, INSTALL, UNLOCK} state_t;

    state_t        state, state_next;
    cmd_t          fifo_mem [FIFO_DEPTH];
    cmd_t          cmd_in, head, work;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] victim_way;
    logic          full, empty, push, pop;

    assign cmd_in = '{unlock: req_unlock, set: req_set, tag: req_tag, way: req_way, lock: req_lock};
    assign head   = fifo_mem[rd_ptr[PW-1:0]];

    // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    // NOTE: command storage is not reset; entry validity comes only from the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= cmd_in;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= IDLE;
            work       <= '0;
            victim_way <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
                work   <= head;
            end
            if (state == VCAP) victim_way <= lru_fill_way;
            state <= state_next;
        end
    end

    // Data outputs follow the working registers and are qualified by their strobes.
    assign lru_fill_set = work.set;
    assign wb_set       = work.set;
    assign wb_way       = victim_way;
    assign tag_set      = work.set;
    assign tag_way      = victim_way;
    assign tag_value    = work.tag;
    assign lru_lock_way = (state == UNLOCK) ? work.way : victim_way;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next     = state;
        lru_fill_en    = 1'b0;
        lru_lock_en    = 1'b0;
        lru_lock_value = 1'b0;
        wb_valid       = 1'b0;
        tag_we         = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_next = head.unlock ? UNLOCK : VREQ;
            end
            VREQ: begin
                lru_fill_en = 1'b1;
                state_next  = VCAP;
            end
            VCAP: begin
                state_next = victim_dirty ? WB : INSTALL;
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_next = INSTALL;
            end
            INSTALL: begin
                tag_we = 1'b1;
                done   = 1'b1;
                if (work.lock) begin
                    lru_lock_en    = 1'b1;
                    lru_lock_value = 1'b1;
                end
                state_next = IDLE;
            end
            UNLOCK: begin
                lru_lock_en = 1'b1;
                done        = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_fill_sequencer.sv
// Directed bench for l2_fill_sequencer: cycle-exact fill/writeback/lock/unlock
// sequences, FIFO backpressure, pointer wrap and asynchronous reset.
module tb_l2_fill_sequencer;

    localparam int NUM_SETS   = 4;
    localparam int NUM_WAYS   = 4;
    localparam int TAG_WIDTH  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SW = $clog2(NUM_SETS);
    localparam int WW = $clog2(NUM_WAYS);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid, req_ready, req_unlock, req_lock;
    logic [SW-1:0]        req_set;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [WW-1:0]        req_way;
    logic                 lru_fill_en;
    logic [SW-1:0]        lru_fill_set;
    logic [WW-1:0]        lru_fill_way;
    logic                 lru_lock_en, lru_lock_value;
    logic [WW-1:0]        lru_lock_way;
    logic                 victim_dirty;
    logic                 wb_valid, wb_ready;
    logic [SW-1:0]        wb_set;
    logic [WW-1:0]        wb_way;
    logic                 tag_we;
    logic [SW-1:0]        tag_set;
    logic [WW-1:0]        tag_way;
    logic [TAG_WIDTH-1:0] tag_value;
    logic                 done, busy;

    l2_fill_sequencer #(
        .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS),
        .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_unlock(req_unlock),
        .req_set(req_set), .req_tag(req_tag), .req_way(req_way), .req_lock(req_lock),
        .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
        .lru_lock_en(lru_lock_en), .lru_lock_value(lru_lock_value), .lru_lock_way(lru_lock_way),
        .victim_dirty(victim_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way),
        .tag_we(tag_we), .tag_set(tag_set), .tag_way(tag_way), .tag_value(tag_value),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Retirement monitor: tag writes must come out in enqueue order.
    logic [TAG_WIDTH-1:0] exp_q[$];
    logic                 mon_en = 1'b0;
    int                   mon_done = 0;

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (tag_we) begin
                if (exp_q.size() == 0) check("order_extra", exp_q.size(), 1);
                else check("order_tag", tag_value, exp_q.pop_front());
            end
            if (done) mon_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic unl, input logic [SW-1:0] s, input logic [TAG_WIDTH-1:0] t,
                        input logic [WW-1:0] w, input logic lk);
        int budget = 0;
        req_valid = 1'b1; req_unlock = unl; req_set = s; req_tag = t; req_way = w; req_lock = lk;
        while (!req_ready && budget < 200) begin
            tick();
            budget++;
        end
        if (!req_ready) check("push_timeout", req_ready, 1);
        tick();
        req_valid = 1'b0;
        if (mon_en && !unl) exp_q.push_back(t);
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while (mon_done < n && c < 1000) begin
            tick();
            c++;
        end
        check("drain_count", mon_done, n);
    endtask

    // One fill command, checked cycle by cycle; stall = extra WB cycles before acceptance.
    task automatic run_fill(input logic [SW-1:0] s, input logic [TAG_WIDTH-1:0] t,
                            input logic [WW-1:0] w, input logic dirty, input logic lk, input int stall);
        lru_fill_way = w;
        victim_dirty = dirty;
        push(1'b0, s, t, '0, lk);
        check("idle_fill_en", lru_fill_en, 0);
        check("idle_busy", busy, 1);
        tick();
        check("vreq_fill_en", lru_fill_en, 1);
        check("vreq_fill_set", lru_fill_set, s);
        tick();
        check("vcap_fill_en", lru_fill_en, 0);
        check("vcap_fill_set", lru_fill_set, s);
        check("vcap_wb_valid", wb_valid, 0);
        tick();
        lru_fill_way = ~w;
        victim_dirty = 1'b0;
        if (dirty) begin
            for (int i = 0; i <= stall; i++) begin
                check("wb_valid_held", wb_valid, 1);
                check("wb_set", wb_set, s);
                check("wb_way", wb_way, w);
                check("wb_no_tag_we", tag_we, 0);
                if (i == stall) wb_ready = 1'b1;
                tick();
            end
        end
        check("inst_tag_we", tag_we, 1);
        check("inst_tag_set", tag_set, s);
        check("inst_tag_way", tag_way, w);
        check("inst_tag_value", tag_value, t);
        check("inst_done", done, 1);
        check("inst_wb_valid", wb_valid, 0);
        check("inst_lock_en", lru_lock_en, lk);
        if (lk) begin
            check("inst_lock_value", lru_lock_value, 1);
            check("inst_lock_way", lru_lock_way, w);
        end
        wb_ready = 1'b0;
        tick();
        check("post_done", done, 0);
        check("post_tag_we", tag_we, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_unlock = 1'b0; req_set = '0; req_tag = '0; req_way = '0; req_lock = 1'b0;
        lru_fill_way = '0; victim_dirty = 1'b0; wb_ready = 1'b0;
        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fill_en", lru_fill_en, 0);
        check("rst_lock_en", lru_lock_en, 0);
        check("rst_lock_value", lru_lock_value, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_tag_we", tag_we, 0);
        check("rst_done", done, 0);
        check("rst_tag_value", tag_value, 0);
        #14 reset = 1'b1;
        tick();

        // Clean fill; wb_ready held high outside WB must be ignored.
        wb_ready = 1'b1;
        run_fill(2'd1, 16'h1234, 2'd2, 1'b0, 1'b0, 0);

        // Dirty fill with writeback stalled 3 cycles.
        run_fill(2'd3, 16'hBEEF, 2'd3, 1'b1, 1'b0, 3);

        // Fill + lock, then unlock the same way.
        run_fill(2'd0, 16'h5A5A, 2'd1, 1'b0, 1'b1, 0);
        push(1'b1, 2'd0, '0, 2'd1, 1'b0);
        check("unl_idle_done", done, 0);
        check("unl_idle_lock_en", lru_lock_en, 0);
        tick();
        check("unl_lock_en", lru_lock_en, 1);
        check("unl_lock_value", lru_lock_value, 0);
        check("unl_lock_way", lru_lock_way, 1);
        check("unl_done", done, 1);
        check("unl_tag_we", tag_we, 0);
        tick();
        check("unl_post_done", done, 0);
        check("unl_post_lock_en", lru_lock_en, 0);
        check("unl_post_busy", busy, 0);

        // FIFO full: hold the FSM in WB, fill the queue, then release.
        mon_en = 1'b1; mon_done = 0;
        lru_fill_way = 2'd0; victim_dirty = 1'b1; wb_ready = 1'b0;
        push(1'b0, 2'd2, 16'hA000, '0, 1'b0);
        tick(); tick(); tick();
        check("full_in_wb", wb_valid, 1);
        victim_dirty = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, SW'(i), 16'hB000 + 16'(i), '0, 1'b0);
        check("full_ready_low", req_ready, 0);
        req_valid = 1'b1; req_unlock = 1'b0; req_set = 2'd3; req_tag = 16'hC0DE; req_lock = 1'b0;
        tick(); tick();
        check("full_ready_stall", req_ready, 0);
        check("full_wb_stall", wb_valid, 1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("full_ready_install", req_ready, 0);
        tick();
        check("full_ready_idle", req_ready, 0);
        tick();
        check("full_ready_after_pop", req_ready, 1);
        tick();
        req_valid = 1'b0;
        exp_q.push_back(16'hC0DE);
        wait_done(6);
        check("full_queue_empty", exp_q.size(), 0);

        // Pointer wrap: 10 back-to-back commands under backpressure.
        mon_done = 0;
        for (int i = 0; i < 10; i++) push(1'b0, SW'(i % 4), 16'hD000 + 16'(i), '0, 1'b0);
        wait_done(10);
        check("wrap_queue_empty", exp_q.size(), 0);
        tick();
        mon_en = 1'b0;

        // Asynchronous reset in the middle of a writeback with another command queued.
        lru_fill_way = 2'd3; victim_dirty = 1'b1; wb_ready = 1'b0;
        push(1'b0, 2'd1, 16'hEEEE, '0, 1'b1);
        tick(); tick(); tick();
        victim_dirty = 1'b0;
        push(1'b0, 2'd2, 16'h7777, '0, 1'b0);
        check("mid_wb_valid", wb_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_wb_valid", wb_valid, 0);
        check("arst_tag_we", tag_we, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_busy", busy, 0);
        #3 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_tag_we", tag_we, 0);
            check("post_rst_wb_valid", wb_valid, 0);
            check("post_rst_lock_en", lru_lock_en, 0);
            check("post_rst_fill_en", lru_fill_en, 0);
            check("post_rst_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
